// File: rtl/board_mem_arbiter_pkg.sv
// board_mem_arbiter_pkg: shared types and constants for the board memory arbiter.
package board_mem_arbiter_pkg;

    localparam int ADDR_W     = 6;
    localparam int CELL_W     = 3;
    localparam int COL_W      = 4;
    localparam int BOARD_COLS = 10;

    typedef logic [ADDR_W-1:0] address_t;
    typedef logic [CELL_W-1:0] cell_t;
    typedef logic [COL_W-1:0]  col_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_START = 2'd1,
        ARB_BURST = 2'd2
    } arb_state_e;

endpackage

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares one row-burst board memory between the display
// (read only) and the game logic (read or write). One burst at a time:
// IDLE (grant) -> START (mem_start) -> BURST (COLS cells) -> IDLE.
// Build option: define BOARD_MEM_ARB_RR_EN to alternate grants on simultaneous
// requests; without it the display always wins a tie.
module board_mem_arbiter
    import board_mem_arbiter_pkg::*;
#(
    parameter int COLS       = BOARD_COLS,
    parameter int LATE_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       disp_req,
    input  logic [5:0] disp_row,
    output logic       disp_gnt,
    output logic       disp_valid,
    output logic [3:0] disp_col,
    output logic [2:0] disp_data,
    input  logic       game_req,
    input  logic       game_we,
    input  logic [5:0] game_row,
    input  logic [2:0] game_wdata,
    output logic       game_gnt,
    output logic       game_valid,
    output logic [3:0] game_col,
    output logic [2:0] game_rdata,
    output logic       mem_start,
    output logic       mem_write_enable,
    output logic       mem_cont,
    output logic [5:0] mem_addr,
    output logic [2:0] mem_wdata,
    input  logic [2:0] mem_rdata,
    output logic       disp_late
);

    localparam logic [1:0] S_IDLE  = ARB_IDLE;
    localparam logic [1:0] S_START = ARB_START;
    localparam logic [1:0] S_BURST = ARB_BURST;

    localparam col_t COL_LAST = col_t'(COLS - 1);

    // The wait counter saturates one above the limit so "exceeded" stays visible.
    localparam int                WAIT_W   = $clog2(LATE_LIMIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(LATE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_THR = WAIT_W'(LATE_LIMIT);

    logic [1:0]        r_state;
    logic              r_owner;   // 1 = game owns the current burst
    address_t          r_row;
    logic              r_we;
    col_t              r_col;
    logic [WAIT_W-1:0] r_wait;
    logic              r_late;

    logic w_idle;
    logic w_start;
    logic w_burst;
    logic w_any_req;
    logic w_pick_game;
    logic w_grant;
    logic w_disp_gnt;
    logic w_disp_own;
    logic w_game_own;

    assign w_idle    = (r_state == S_IDLE);
    assign w_start   = (r_state == S_START);
    assign w_burst   = (r_state == S_BURST);
    assign w_any_req = disp_req | game_req;

`ifdef BOARD_MEM_ARB_RR_EN
    logic r_last;   // owner of the most recent grant, 1 = game

    // On a tie the requester that was not granted last time wins.
    assign w_pick_game = game_req & (~disp_req | ~r_last);

    // Remember who was granted last; reset value lets the display win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_last <= 1'b1;
        else if (w_grant)
            r_last <= w_pick_game;
    end
`else
    // Fixed priority: the display always wins a tie.
    assign w_pick_game = game_req & ~disp_req;
`endif

    // Grant is combinational in IDLE; gated by reset so every output is 0 in reset.
    assign w_grant    = w_idle & w_any_req & reset_n;
    assign w_disp_gnt = w_grant & ~w_pick_game;
    assign disp_gnt   = w_disp_gnt;
    assign game_gnt   = w_grant & w_pick_game;

    // Burst sequencer: latch the winner in IDLE, then START and COLS burst cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_row   <= '0;
            r_we    <= 1'b0;
            r_col   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_START;
                        r_owner <= w_pick_game;
                        r_row   <= w_pick_game ? game_row : disp_row;
                        r_we    <= w_pick_game & game_we;
                    end
                end
                S_START: begin
                    r_state <= S_BURST;
                    r_col   <= '0;
                end
                S_BURST: begin
                    if (r_col == COL_LAST)
                        r_state <= S_IDLE;
                    else
                        r_col <= r_col + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_disp_own = w_burst & ~r_owner;
    assign w_game_own = w_burst & r_owner;

    assign mem_start        = w_start;
    assign mem_cont         = w_burst;
    assign mem_addr         = (w_start | w_burst) ? r_row : '0;
    assign mem_write_enable = (w_start | w_burst) & r_we;
    assign mem_wdata        = (w_game_own & r_we) ? game_wdata : '0;

    assign disp_valid = w_disp_own;
    assign disp_col   = w_disp_own ? r_col : '0;
    assign disp_data  = w_disp_own ? mem_rdata : '0;

    assign game_valid = w_game_own;
    assign game_col   = w_game_own ? r_col : '0;
    assign game_rdata = (w_game_own & ~r_we) ? mem_rdata : '0;

    // Count cycles the display has been kept waiting; any grant or drop clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_wait <= '0;
        else if (!disp_req || w_disp_gnt)
            r_wait <= '0;
        else if (r_wait != WAIT_MAX)
            r_wait <= r_wait + 1'b1;
    end

    // Sticky lateness flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_late <= 1'b0;
        else if (r_wait > WAIT_THR)
            r_late <= 1'b1;
    end

    assign disp_late = r_late;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: scoreboard bench for board_mem_arbiter with a row-burst
// memory model. A second instance with LATE_LIMIT=8 shares the stimulus and is
// only observed for its lateness flag.
module tb_board_mem_arbiter;

    localparam logic [2:0] EV_DGNT  = 3'd1;
    localparam logic [2:0] EV_GGNT  = 3'd2;
    localparam logic [2:0] EV_START = 3'd3;
    localparam logic [2:0] EV_DV    = 3'd4;
    localparam logic [2:0] EV_GV    = 3'd5;
    localparam logic [2:0] EV_GW    = 3'd6;
    localparam logic [2:0] EV_STRAY = 3'd7;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] cyc;
        logic [5:0]  a;
        logic [3:0]  col;
        logic [2:0]  data;
        logic        flag;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       disp_req, game_req, game_we;
    logic [5:0] disp_row, game_row;
    logic [2:0] game_wdata;
    logic       disp_gnt, disp_valid, game_gnt, game_valid;
    logic [3:0] disp_col, game_col;
    logic [2:0] disp_data, game_rdata;
    logic       mem_start, mem_write_enable, mem_cont;
    logic [5:0] mem_addr;
    logic [2:0] mem_wdata, mem_rdata;
    logic       disp_late;

    logic       x_dgnt, x_dvalid, x_ggnt, x_gvalid, x_mstart, x_mwe, x_mcont, late8;
    logic [3:0] x_dcol, x_gcol;
    logic [2:0] x_ddata, x_grdata, x_mwdata;
    logic [5:0] x_maddr;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t expq[$];

    logic [2:0] ref_mem [64][10];
    logic [2:0] mem [64][10];
    logic       m_init = 1'b0;
    logic [5:0] m_row = '0;
    logic       m_we = 1'b0;
    logic [3:0] m_k = '0;

    logic [30:0] all_out;
    assign all_out = {disp_gnt, disp_valid, disp_col, disp_data, game_gnt, game_valid,
                      game_col, game_rdata, mem_start, mem_write_enable, mem_cont,
                      mem_addr, mem_wdata, disp_late};

    // Game write pattern: cell value = column + 1 (wraps in 3 bits).
    assign game_wdata = 3'(game_col + 4'd1);
    assign mem_rdata  = (m_k < 4'd10) ? mem[m_row][m_k] : 3'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    board_mem_arbiter u_dut (
        .clk(clk), .reset_n(reset_n),
        .disp_req(disp_req), .disp_row(disp_row), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .disp_col(disp_col), .disp_data(disp_data),
        .game_req(game_req), .game_we(game_we), .game_row(game_row),
        .game_wdata(game_wdata), .game_gnt(game_gnt), .game_valid(game_valid),
        .game_col(game_col), .game_rdata(game_rdata),
        .mem_start(mem_start), .mem_write_enable(mem_write_enable), .mem_cont(mem_cont),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .disp_late(disp_late)
    );

    board_mem_arbiter #(.COLS(10), .LATE_LIMIT(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n),
        .disp_req(disp_req), .disp_row(disp_row), .disp_gnt(x_dgnt),
        .disp_valid(x_dvalid), .disp_col(x_dcol), .disp_data(x_ddata),
        .game_req(game_req), .game_we(game_we), .game_row(game_row),
        .game_wdata(game_wdata), .game_gnt(x_ggnt), .game_valid(x_gvalid),
        .game_col(x_gcol), .game_rdata(x_grdata),
        .mem_start(x_mstart), .mem_write_enable(x_mwe), .mem_cont(x_mcont),
        .mem_addr(x_maddr), .mem_wdata(x_mwdata), .mem_rdata(3'd0),
        .disp_late(late8)
    );

    // Board memory model: preloads on the first edge, then follows the bursts.
    always @(posedge clk) begin
        if (!m_init) begin
            for (int r = 0; r < 64; r++)
                for (int c = 0; c < 10; c++)
                    mem[r][c] <= 3'((r * 3 + c) % 8);
            m_init <= 1'b1;
        end else if (mem_start) begin
            m_row <= mem_addr;
            m_we  <= mem_write_enable;
            m_k   <= '0;
        end else if (mem_cont) begin
            if (m_we && m_k < 4'd10) mem[m_row][m_k] <= mem_wdata;
            m_k <= m_k + 4'd1;
        end
    end

    function automatic ev_t mk(input logic [2:0] k, input int c, input logic [5:0] a,
                               input logic [3:0] col, input logic [2:0] d, input logic f);
        ev_t e;
        e.kind = k; e.cyc = c; e.a = a; e.col = col; e.data = d; e.flag = f;
        return e;
    endfunction

    task automatic check_ev(input ev_t got);
        ev_t e;
        n_cmp++;
        if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d a=%0d col=%0d data=%0d flag=%0d, required none",
                     got.kind, got.cyc, got.a, got.col, got.data, got.flag);
        end else begin
            e = expq.pop_front();
            if (got !== e) begin
                n_bad++;
                $display("FAIL event: got kind=%0d cyc=%0d a=%0d col=%0d data=%0d flag=%0d, required kind=%0d cyc=%0d a=%0d col=%0d data=%0d flag=%0d",
                         got.kind, got.cyc, got.a, got.col, got.data, got.flag,
                         e.kind, e.cyc, e.a, e.col, e.data, e.flag);
            end
        end
    endtask

    // Monitor: every DUT event seen mid-cycle is popped against the scoreboard.
    always @(negedge clk) begin
        if (disp_gnt)   check_ev(mk(EV_DGNT, cyc, 6'd0, 4'd0, 3'd0, 1'b0));
        if (game_gnt)   check_ev(mk(EV_GGNT, cyc, 6'd0, 4'd0, 3'd0, 1'b0));
        if (mem_start)  check_ev(mk(EV_START, cyc, mem_addr, 4'd0, 3'd0, mem_write_enable));
        if (disp_valid) check_ev(mk(EV_DV, cyc, 6'd0, disp_col, disp_data, mem_cont));
        if (game_valid) check_ev(mk(m_we ? EV_GW : EV_GV, cyc, 6'd0, game_col,
                                    m_we ? mem_wdata : game_rdata, mem_cont));
        if (mem_cont && !disp_valid && !game_valid)
            check_ev(mk(EV_STRAY, cyc, mem_addr, 4'd0, 3'd0, 1'b1));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected events of one burst granted in cycle c0 (first ncols cells).
    task automatic exp_burst(input bit game, input int c0, input logic [5:0] row,
                             input bit we, input int ncols);
        expq.push_back(mk(game ? EV_GGNT : EV_DGNT, c0, 6'd0, 4'd0, 3'd0, 1'b0));
        expq.push_back(mk(EV_START, c0 + 1, row, 4'd0, 3'd0, we));
        for (int k = 0; k < ncols; k++) begin
            logic [2:0] d;
            if (we) begin
                d = 3'(k + 1);
                ref_mem[row][k] = d;
            end else begin
                d = ref_mem[row][k];
            end
            expq.push_back(mk(game ? (we ? EV_GW : EV_GV) : EV_DV, c0 + 2 + k,
                              6'd0, 4'(k), d, 1'b1));
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 100 && expq.size() != 0; i++) tick();
        chk(nm, expq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 10; c++)
                ref_mem[r][c] = 3'((r * 3 + c) % 8);
        reset_n = 1'b0; disp_req = 1'b1; game_req = 1'b1; game_we = 1'b1;
        disp_row = 6'd1; game_row = 6'd2;
        tick(); tick();
        @(negedge clk);
        chk("reset_outputs", {1'b0, all_out}, 0);
        chk("reset_late8", {31'd0, late8}, 0);
        tick();
        disp_req = 1'b0; game_req = 1'b0; game_we = 1'b0;
        reset_n = 1'b1;
        tick();

        // Display read of row 5; inputs changed after grant and a short game pulse are ignored.
        tick(); c0 = cyc;
        disp_req = 1'b1; disp_row = 6'd5;
        exp_burst(1'b0, c0, 6'd5, 1'b0, 10);
        tick(); disp_req = 1'b0; disp_row = 6'd40;
        tick(); tick(); game_req = 1'b1; game_row = 6'd33;
        tick(); game_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        drain("drain_disp_read");

        // Game write row 3 with column+1, then read it back.
        tick(); c0 = cyc;
        game_req = 1'b1; game_we = 1'b1; game_row = 6'd3;
        exp_burst(1'b1, c0, 6'd3, 1'b1, 10);
        tick(); game_req = 1'b0; game_we = 1'b0; game_row = 6'd0;
        for (int i = 0; i < 12; i++) tick();
        drain("drain_game_write");
        tick(); c0 = cyc;
        game_req = 1'b1; game_we = 1'b0; game_row = 6'd3;
        exp_burst(1'b1, c0, 6'd3, 1'b0, 10);
        tick(); game_req = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        drain("drain_game_readback");

        // Both requesters held for four bursts.
        tick(); c0 = cyc;
        disp_req = 1'b1; disp_row = 6'd7; game_req = 1'b1; game_we = 1'b0; game_row = 6'd9;
        for (int i = 0; i < 4; i++) begin
`ifdef BOARD_MEM_ARB_RR_EN
            if (i % 2 == 1) exp_burst(1'b1, c0 + 12 * i, 6'd9, 1'b0, 10);
            else            exp_burst(1'b0, c0 + 12 * i, 6'd7, 1'b0, 10);
`else
            exp_burst(1'b0, c0 + 12 * i, 6'd7, 1'b0, 10);
`endif
        end
        for (int i = 0; i < 37; i++) tick();
        disp_req = 1'b0; game_req = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        drain("drain_contention");
`ifndef BOARD_MEM_ARB_RR_EN
        chk("late_after_contention", {31'd0, disp_late}, 0);
`endif

        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        chk("late8_cleared_by_reset", {31'd0, late8}, 0);
        tick();

        // Display arrives one cycle after a game grant and waits 11 cycles.
        tick(); c0 = cyc;
        game_req = 1'b1; game_we = 1'b0; game_row = 6'd12;
        exp_burst(1'b1, c0, 6'd12, 1'b0, 10);
        tick();
        game_req = 1'b0; game_row = 6'd0; disp_req = 1'b1; disp_row = 6'd20;
        exp_burst(1'b0, c0 + 12, 6'd20, 1'b0, 10);
        for (int i = 0; i < 4; i++) tick();
        chk("late8_early", {31'd0, late8}, 0);
        for (int i = 0; i < 6; i++) tick();
        chk("late8_before_grant", {31'd0, late8}, 1);
        tick(); tick();
        disp_req = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        chk("late8_sticky", {31'd0, late8}, 1);
        chk("late16_clear", {31'd0, disp_late}, 0);
        drain("drain_late");

        // Reset in burst cell 4, then a fresh full burst.
        tick(); c0 = cyc;
        disp_req = 1'b1; disp_row = 6'd2;
        exp_burst(1'b0, c0, 6'd2, 1'b0, 4);
        tick(); disp_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        @(negedge clk);
        chk("midburst_reset_outputs", {1'b0, all_out}, 0);
        tick(); tick();
        reset_n = 1'b1;
        chk("queue_after_abort", expq.size(), 0);
        tick(); c0 = cyc;
        disp_req = 1'b1; disp_row = 6'd2;
        exp_burst(1'b0, c0, 6'd2, 1'b0, 10);
        tick(); disp_req = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 Parameter COLS, default 10, cells per row burst.
REQ-002 Parameter LATE_LIMIT, default 16, max cycles display may wait for grant before lateness is flagged.
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 disp_req  input  1  display requests a read burst of one row.
REQ-006 disp_row  input  6  display row address (address_t).
REQ-007 disp_gnt  output  1  one-cycle pulse: display request accepted.
REQ-008 disp_valid  output  1  disp_data/disp_col valid this cycle.
REQ-009 disp_col  output  4  column index of current cell.
REQ-010 disp_data  output  3  cell value read.
REQ-011 game_req  input  1  game requests a row burst.
REQ-012 game_we  input  1  1 = write burst, 0 = read burst; sampled with game_req.
REQ-013 game_row  input  6  game row address (address_t).
REQ-014 game_wdata  input  3  write data for cell game_col; must be valid combinationally while game_valid=1.
REQ-015 game_gnt  output  1  one-cycle pulse: game request accepted.
REQ-016 game_valid  output  1  read: game_rdata valid; write: game_wdata consumed this cycle.
REQ-017 game_col  output  4  column index of current cell.
REQ-018 game_rdata  output  3  cell value read.
REQ-019 mem_start, mem_write_enable, mem_cont  output  1 each  board memory burst controls.
REQ-020 mem_addr  output  6  row address to memory (address_t).
REQ-021 mem_wdata  output  3  write data to memory.
REQ-022 mem_rdata  input  3  memory read data, combinational for current cell.
REQ-023 disp_late  output  1  sticky lateness flag.

Function
REQ-024 FSM states: IDLE, START, BURST; one burst at a time.
REQ-025 IDLE: if any req, latch owner, row, we; pulse owner's gnt same cycle; next state START; else stay IDLE.
REQ-026 START (1 cycle): mem_start=1, mem_addr=latched row, mem_write_enable=latched we (0 for display); column counter cleared to 0; next BURST.
REQ-027 BURST: mem_cont=1 every cycle for exactly COLS cycles; column counter k=0..COLS-1; owner's valid=1 and col=k each cycle.
REQ-028 Read data: owner's data output = mem_rdata in BURST cycle k (cell k); non-owner's valid=0.
REQ-029 Write: mem_wdata = game_wdata combinationally during game write BURST; mem_wdata=0 otherwise.
REQ-030 After cycle k=COLS-1, return to IDLE; one IDLE cycle mandatory between bursts (total COLS+2 cycles per burst).
REQ-031 Request dropped before gnt is discarded without effect; request held after its burst is a new request.
REQ-032 Requester inputs changed after gnt are ignored until burst end.
REQ-033 Outside START/BURST all mem_* outputs are 0.
REQ-034 Wait counter: increments each cycle disp_req=1 and disp_gnt=0, saturates, clears on disp_gnt or disp_req=0; disp_late set when counter exceeds LATE_LIMIT, held until reset.

Reset
REQ-035 reset_n=0 forces IDLE immediately; all outputs 0; wait counter 0; disp_late 0; latched owner cleared.
REQ-036 Reset mid-burst abandons the burst; no further mem_cont; next burst restarts via mem_start.

Configuration
REQ-037 BOARD_MEM_ARB_RR_EN defined: on simultaneous requests, grant alternates; last-owner bit toggles on each grant, reset value = game last (display wins first tie).
REQ-038 BOARD_MEM_ARB_RR_EN undefined: display always wins simultaneous requests; no last-owner state.

Structure
REQ-039 Shared package: address_t, cell_t (3-bit), BOARD_COLS constant, arbiter state enum.
REQ-040 Single module; no sub-module required.

Verification
REQ-041 disp_req=1 row=5, idle -> disp_gnt at cycle 0, mem_start addr=5 cycle 1, disp_valid cols 0..9 cycles 2..11 with disp_data=preloaded row 5.
REQ-042 game write row 3, wdata=col+1 -> mem_write_enable=1 at start; memory row 3 holds 1..7,0,1,2 (3-bit wrap) afterwards; readback matches.
REQ-043 Both req same cycle, RR off -> display granted 4 times in a row while game starves; disp_late stays 0.
REQ-044 Both req continuously, RR on -> grants alternate D,G,D,G; each burst 12 cycles.
REQ-045 disp_req asserted 1 cycle after game gnt, LATE_LIMIT=8 -> display waits 11 cycles, disp_late=1, stays 1 after grant.
REQ-046 reset_n low at BURST k=4 -> all outputs 0 same cycle; after release, new disp_req yields full 10-cell burst from col 0.
